// File: rtl/shift_pkg.sv
// Shared widths, pipeline occupancy states and stage payload layouts for the shift operand stage.
// Latency: none; this package holds only types and constants.
// Backpressure: none; this package holds only types and constants.
package shift_pkg;

  localparam int DATA_W     = 32;
  localparam int SHAMT_W    = 5;
  localparam int REG_ADDR_W = 5;

  // Occupancy of the two-stage pipe, encoded as {s1_valid, s2_valid}
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    S2_ONLY = 2'b01,
    S1_ONLY = 2'b10,
    BOTH    = 2'b11
  } pipe_state_e;

  // Operand register: value to shift, resolved shift amount, destination index
  typedef struct packed {
    logic [DATA_W-1:0]     rt;
    logic [SHAMT_W-1:0]    amt;
    logic [REG_ADDR_W-1:0] rd;
  } s1_t;

  // Result register: writeback value and destination index
  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [REG_ADDR_W-1:0] rd;
  } s2_t;

endpackage

// File: rtl/pipe_stage.sv
// Valid-qualified pipeline register with a load enable and an asynchronous clear.
// Latency: 1 cycle from load to q/valid.
// Backpressure: none internally; the parent decides when to load and when to drain.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // A load refills the slot; a drain without a load empties it; otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        q     <= d;
      end else if (drain) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shift_operand_stage.sv
// Registers srl/srlv operands for an external shifter and registers its result for writeback; stats counter under SHIFT_STATS_EN.
// Latency: 2 cycles from acceptance to out_valid, one operation per cycle sustained.
// Backpressure: out_ready low holds the result; in_ready drops only when both stages are full and the result cannot leave.
module shift_operand_stage
  import shift_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_rt,
  input  logic [DATA_W-1:0]     in_rs,
  input  logic [SHAMT_W-1:0]    in_shamt,
  input  logic                  in_var,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic [DATA_W-1:0]     sh_a,
  output logic [DATA_W-1:0]     sh_b,
  input  logic [DATA_W-1:0]     sh_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd
`ifdef SHIFT_STATS_EN
  ,
  output logic [CNT_W-1:0]      op_count
`endif
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_load;
  logic        s2_load;
  logic        s2_drain;
  logic        s2_free;
  s1_t         s1_d;
  s1_t         s1_q;
  s2_t         s2_d;
  s2_t         s2_q;
  pipe_state_e state;

  // Only the low bits of rs carry a shift amount; the rest is ignored by srlv
  logic unused_rs_hi;
  assign unused_rs_hi = ^in_rs[DATA_W-1:SHAMT_W];

  // Occupancy view of the two valid bits; transitions come from the stage loads/drains
  always_comb begin
    state = pipe_state_e'({s1_valid, s2_valid});
  end

  // Ready depends only on registered state and out_ready, never on in_valid
  assign s2_free  = !s2_valid || out_ready;
  assign in_ready = (state != BOTH) || out_ready;

  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_free;
  assign s2_drain = s2_valid && out_ready;

  // Resolve the shift amount at acceptance so the shifter sees a settled operand
  always_comb begin
    s1_d     = '0;
    s1_d.rt  = in_rt;
    s1_d.amt = in_var ? in_rs[SHAMT_W-1:0] : in_shamt;
    s1_d.rd  = in_rd;
  end

  // Writes to r0 are forced to zero so writeback never corrupts the hardwired register
  always_comb begin
    s2_d        = '0;
    s2_d.result = (s1_q.rd == '0) ? '0 : sh_result;
    s2_d.rd     = s1_q.rd;
  end

  pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (s1_load),
    .drain (s2_load),
    .d     (s1_d),
    .valid (s1_valid),
    .q     (s1_q)
  );

  pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (s2_load),
    .drain (s2_drain),
    .d     (s2_d),
    .valid (s2_valid),
    .q     (s2_q)
  );

  // Shifter operands come straight from the operand register, so they hold for a full cycle
  assign sh_a = s1_q.rt;
  assign sh_b = {{(DATA_W-SHAMT_W){1'b0}}, s1_q.amt};

  assign out_valid  = s2_valid;
  assign out_result = s2_q.result;
  assign out_rd     = s2_q.rd;

`ifdef SHIFT_STATS_EN
  // Count completed writebacks, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/shift_operand_stage.md
SHIFT_OPERAND_STAGE -- requirements
Module: shift_operand_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream decode stage presents a shift operation.
REQ-005 SHALL have port in_ready, output, 1 bit: this stage accepts the operation this cycle.
REQ-006 SHALL have ports in_rt and in_rs, input, 32 bits each: in_rt is the value to shift and in_rs supplies the variable shift amount.
REQ-007 SHALL have port in_shamt, input, 5 bits: the immediate shift amount.
REQ-008 SHALL have port in_var, input, 1 bit: 1 selects in_rs[4:0] (srlv), 0 selects in_shamt (srl).
REQ-009 SHALL have port in_rd, input, 5 bits: the destination register index.
REQ-010 SHALL have ports sh_a and sh_b, output, 32 bits each: operands driven to the combinational srl shifter.
REQ-011 SHALL have port sh_result, input, 32 bits: the shifter output.
REQ-012 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the writeback handshake.
REQ-013 SHALL have ports out_result (output, 32 bits) and out_rd (output, 5 bits): the value and index to write back.
REQ-014 SHALL have port op_count, output, CNT_W bits, present only under SHIFT_STATS_EN.

Function
REQ-015 SHALL hold a two-stage pipeline: S1 (operand register) and S2 (result register), each with its own valid bit.
REQ-016 SHALL treat the two valid bits as an FSM with states EMPTY, S1_ONLY, S2_ONLY and BOTH; transitions follow REQ-017 to REQ-019.
REQ-017 SHALL define s2_free = !s2_valid || out_ready and in_ready = !s1_valid || s2_free, with no combinational path from in_valid to in_ready.
REQ-018 SHALL, on in_valid && in_ready, load S1 with sh_a = in_rt, sh_b = {27'b0, in_var ? in_rs[4:0] : in_shamt} and rd = in_rd.
REQ-019 SHALL, on s1_valid && s2_free, load S2 with out_result = (rd == 0) ? 0 : sh_result and out_rd = rd.
REQ-020 SHALL drive sh_a and sh_b from S1 only, so they are stable for a whole cycle.
REQ-021 SHALL assert out_valid exactly 2 cycles after acceptance when not stalled, and sustain throughput of one operation per cycle.
REQ-022 SHALL, when S2 drains, S1 advances and a new operation is accepted in the same cycle, perform all three without a bubble.
REQ-023 SHALL hold S2 contents and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL complete operations strictly in acceptance order, with no drop and no duplicate.
REQ-025 SHALL drive sh_b[31:5] as 0 at all times.

Reset
REQ-026 SHALL, while rst_n = 0, asynchronously clear both valid bits, sh_a, sh_b, out_result, out_rd and op_count to 0.
REQ-027 SHALL hold in_ready = 1 during reset and after release while EMPTY.
REQ-028 SHALL discard in-flight operations when reset is asserted mid-operation, and SHALL emit none of them after release.

Configuration
REQ-029 SHALL, with SHIFT_STATS_EN defined, increment op_count on each out_valid && out_ready and saturate at all-ones.
REQ-030 SHALL, without SHIFT_STATS_EN, omit the op_count port and its counter, with all other behaviour identical.

Structure
REQ-031 SHALL take DATA_W = 32, SHAMT_W = 5 and REG_ADDR_W = 5 from the shared package shift_pkg.
REQ-032 SHALL implement S1 and S2 as two instances of one sub-module pipe_stage, a valid-qualified register with load enable and async clear.
REQ-033 SHALL keep the shifter external; this block contains no shift logic.

Verification
REQ-034 SHALL cover: in_rt = 0x80000000, in_shamt = 4, in_var = 0, in_rd = 3 -> next cycle sh_a = 0x80000000, sh_b = 4; 2 cycles after acceptance out_result = 0x08000000, out_rd = 3.
REQ-035 SHALL cover: in_var = 1, in_rs = 0xFFFFFFE3, in_shamt = 9, in_rt = 0xF0 -> sh_b = 3, out_result = 0x1E.
REQ-036 SHALL cover: in_rd = 0 with in_rt = 0xFFFFFFFF, shift amount 0 -> out_valid = 1, out_result = 0.
REQ-037 SHALL cover: three back-to-back operations with out_ready = 0 -> in_ready drops after two are accepted; after out_ready = 1 all three emerge in order, one per cycle.
REQ-038 SHALL cover: rst_n pulsed low in state BOTH -> out_valid = 0 with no clock edge; no stale result after release.
REQ-039 SHALL cover, under SHIFT_STATS_EN with CNT_W = 4: 17 completed operations -> op_count = 0xF.
